// File: rtl/instr_enc_32_pkg.sv
// Shared types for the RV32 instruction encoder: instruction format codes,
// the decoded-field request record and the FIFO entry layout.
package instr_enc_32_pkg;

    typedef enum logic [2:0] {
        INSTR_R = 3'd0,
        INSTR_I = 3'd1,
        INSTR_S = 3'd2,
        INSTR_B = 3'd3,
        INSTR_U = 3'd4,
        INSTR_J = 3'd5
    } instr_type_e;

    typedef struct packed {
        logic [2:0]  instr_type;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } enc_req_t;

    typedef struct packed {
        logic [31:0] ir;
        logic        err;
    } fifo_entry_t;

    localparam int ENC_REQ_W = $bits(enc_req_t);

    // True when v[31:lsb] is a pure sign extension (all zeros or all ones).
    function automatic logic upper_all_equal(input logic [31:0] v, input int unsigned lsb);
        logic [31:0] s;
        s = $signed(v) >>> lsb;
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/instr_pack_32.sv
// Combinational RV32 field packer. Immediate range checking is compiled in
// only when IMM_RANGE_CHECK_EN is defined; unknown types always flag err.
module instr_pack_32
    import instr_enc_32_pkg::*;
(
    input  logic [ENC_REQ_W-1:0] req_flat,
    output logic [31:0]          ir,
    output logic                 err
);

    enc_req_t req;
    logic     type_err;
    logic     range_err;

    assign req = enc_req_t'(req_flat);

    always_comb begin
        ir       = '0;
        type_err = 1'b0;
        case (req.instr_type)
            INSTR_R: ir = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
            INSTR_I: ir = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
            INSTR_S: ir = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
            INSTR_B: ir = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                           req.imm[4:1], req.imm[11], req.opcode};
            INSTR_U: ir = {req.imm[31:12], req.rd, req.opcode};
            INSTR_J: ir = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                           req.rd, req.opcode};
            default: type_err = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Word is still packed from truncated bits; err only marks the loss.
    always_comb begin
        range_err = 1'b0;
        case (req.instr_type)
            INSTR_I, INSTR_S: range_err = !upper_all_equal(req.imm, 11);
            INSTR_B:          range_err = !upper_all_equal(req.imm, 12) || req.imm[0];
            INSTR_J:          range_err = !upper_all_equal(req.imm, 20) || req.imm[0];
            INSTR_U:          range_err = (req.imm[11:0] != 12'h000);
            default:          range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    assign err = type_err | range_err;

endmodule

// File: rtl/instr_enc_32.sv
// RV32 instruction encoder with a DEPTH-entry valid/ready FIFO and registered head.
// Optional immediate range checking: define IMM_RANGE_CHECK_EN.
module instr_enc_32
    import instr_enc_32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_type,
    input  logic [6:0]             in_opcode,
    input  logic [4:0]             in_rd,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    input  logic [2:0]             in_funct3,
    input  logic [6:0]             in_funct7,
    input  logic [31:0]            in_imm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_ir,
    output logic                   out_err,
    output logic [$clog2(DEPTH):0] count
);

    localparam int             PW   = $clog2(DEPTH);
    localparam int             CW   = PW + 1;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    enc_req_t     req;
    logic [31:0]  pack_ir;
    logic         pack_err;
    fifo_entry_t  wdata;

    fifo_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    fifo_entry_t  head_reg, head_next;
    logic         out_valid_reg;
    logic         push, pop;

    assign req = '{instr_type: in_type, opcode: in_opcode, rd: in_rd, rs1: in_rs1,
                   rs2: in_rs2, funct3: in_funct3, funct7: in_funct7, imm: in_imm};

    instr_pack_32 u_pack (
        .req_flat (req),
        .ir       (pack_ir),
        .err      (pack_err)
    );

    assign wdata = '{ir: pack_ir, err: pack_err};

    assign in_ready = (count_reg != FULL) && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid_reg && out_ready && !flush;

    // The head register tracks what the FIFO front will be after this edge,
    // taking the incoming word directly when it lands in an empty slot at the front.
    always_comb begin
        rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
        count_next  = count_reg;
        if (flush)
            count_next = '0;
        else if (push && !pop)
            count_next = count_reg + 1'b1;
        else if (pop && !push)
            count_next = count_reg - 1'b1;

        head_next = '0;
        if (count_next != '0) begin
            if (push && ((count_reg == '0) || (pop && count_reg == ONE)))
                head_next = wdata;
            else
                head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            head_reg      <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push)
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                rd_ptr_reg <= rd_ptr_next;
            end
            count_reg     <= count_next;
            head_reg      <= head_next;
            out_valid_reg <= (count_next != '0);
        end
    end

    assign out_valid = out_valid_reg;
    assign out_ir    = head_reg.ir;
    assign out_err   = head_reg.err;
    assign count     = count_reg;

endmodule
